// File: rtl/axi_wr_route_ctrl.sv
// Write-path routing controller for a 1-master/2-slave AXI interconnect.
// Decodes AWADDR, sequences AW/W/B with one transaction outstanding, and completes unmapped writes locally with DECERR.
module axi_wr_route_ctrl #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] S0_BASE     = ADDR_WIDTH'(32'h0000_0000),
  parameter logic [ADDR_WIDTH-1:0] S1_BASE     = ADDR_WIDTH'(32'h4000_0000),
  parameter logic [ADDR_WIDTH-1:0] REGION_MASK = ADDR_WIDTH'(32'hF000_0000)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] M_AWADDR,
  input  logic [7:0]            M_AWLEN,
  input  logic                  M_AWVALID,
  output logic                  M_AWREADY,
  input  logic                  M_WVALID,
  input  logic                  M_WLAST,
  output logic                  M_WREADY,
  output logic                  M_BVALID,
  output logic [1:0]            M_BRESP,
  input  logic                  M_BREADY,
  input  logic [1:0]            S_AWREADY,
  input  logic [1:0]            S_WREADY,
  input  logic [1:0]            S_BVALID,
  input  logic [1:0]            S_BRESP0,
  input  logic [1:0]            S_BRESP1,
  output logic [1:0]            S_AWVALID,
  output logic [1:0]            S_WVALID,
  output logic [1:0]            S_BREADY,
  output logic                  route_sel,
  output logic                  route_en
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_t     state, state_nxt;
  logic       sel, decerr, last_err;
  logic [7:0] len, beat;
  logic       s0_hit, s1_hit;
  logic       last_beat;
  logic       w_hs;
  logic [1:0] sel_bresp;

  assign s0_hit    = (M_AWADDR & REGION_MASK) == S0_BASE;
  assign s1_hit    = (M_AWADDR & REGION_MASK) == S1_BASE;
  assign last_beat = (beat == len);
  assign sel_bresp = sel ? S_BRESP1 : S_BRESP0;

  // NOTE: control state is reset asynchronously so an abort drops all handshakes immediately.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    state_nxt = state;
    M_AWREADY = 1'b0;
    M_WREADY  = 1'b0;
    M_BVALID  = 1'b0;
    M_BRESP   = RESP_OKAY;
    S_AWVALID = 2'b00;
    S_WVALID  = 2'b00;
    S_BREADY  = 2'b00;
    w_hs      = 1'b0;
    unique case (state)
      IDLE: begin
        if (M_AWVALID) state_nxt = ADDR;
      end
      ADDR: begin
        if (decerr) begin
          M_AWREADY = 1'b1;
          state_nxt = DATA;
        end else begin
          S_AWVALID[sel] = 1'b1;
          M_AWREADY      = S_AWREADY[sel];
          if (S_AWREADY[sel]) state_nxt = DATA;
        end
      end
      DATA: begin
        if (decerr) begin
          M_WREADY = 1'b1;
        end else begin
          S_WVALID[sel] = M_WVALID;
          M_WREADY      = S_WREADY[sel];
        end
        w_hs = M_WVALID && M_WREADY;
        // Termination counts beats; WLAST only feeds the error flag.
        if (w_hs && last_beat) state_nxt = RESP;
      end
      RESP: begin
        if (decerr) begin
          M_BVALID = 1'b1;
          M_BRESP  = RESP_DECERR;
        end else begin
          M_BVALID      = S_BVALID[sel];
          S_BREADY[sel] = M_BREADY;
          M_BRESP       = (last_err && sel_bresp == RESP_OKAY) ? RESP_SLVERR : sel_bresp;
        end
        if (M_BVALID && M_BREADY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sel      <= 1'b0;
      decerr   <= 1'b0;
      len      <= 8'd0;
      beat     <= 8'd0;
      last_err <= 1'b0;
    end else if (state == IDLE && M_AWVALID) begin
      len      <= M_AWLEN;
      sel      <= !s0_hit && s1_hit;
      decerr   <= !s0_hit && !s1_hit;
      beat     <= 8'd0;
      last_err <= 1'b0;
    end else if (w_hs) begin
      if (M_WLAST != last_beat) last_err <= 1'b1;
      // Holding on the final beat keeps a 256-beat burst from wrapping.
      if (!last_beat) beat <= beat + 8'd1;
    end
  end

  assign route_en  = (state != IDLE) && !decerr;
  assign route_sel = route_en && sel;

endmodule

// File: doc/axi_wr_route_ctrl.md
# axi_wr_route_ctrl

Write-path routing controller for the 1-master/2-slave AXI interconnect. It accepts a master write transaction, decodes AWADDR to one of two slaves, and sequences the AW, W and B phases through a single-outstanding FSM. It drives the select/enable pair of the downstream 1x2 channel demultiplexers and returns the B response. Addresses that match neither slave are completed locally with DECERR.

## Interface
- ADDR_WIDTH, 32, AWADDR width
- S0_BASE, 32'h0000_0000, slave 0 region base
- S1_BASE, 32'h4000_0000, slave 1 region base
- REGION_MASK, 32'hF000_0000, decode mask; slave n hit when (AWADDR & REGION_MASK) == Sn_BASE, S0 checked first
- ACLK  in  1  clock, rising edge
- ARESET  in  1  asynchronous, active-high reset
- M_AWADDR  in  ADDR_WIDTH  master write address
- M_AWLEN  in  8  burst length minus 1
- M_AWVALID  in  1  master address valid
- M_AWREADY  out  1  address accepted
- M_WVALID, M_WLAST  in  1 each  master write beat valid / last
- M_WREADY  out  1  beat accepted
- M_BVALID  out  1  response valid to master
- M_BRESP  out  2  response code to master
- M_BREADY  in  1  master response ready
- S_AWREADY, S_WREADY, S_BVALID  in  2 each  per-slave ready/valid, bit n = slave n
- S_BRESP0, S_BRESP1  in  2 each  per-slave response
- S_AWVALID, S_WVALID, S_BREADY  out  2 each  per-slave valid/ready, one-hot or zero
- route_sel  out  1  demux select (0 = slave 0, 1 = slave 1)
- route_en  out  1  demux enable; high only while a decoded transaction is routed

## Operation
- States: IDLE, ADDR, DATA, RESP. Registers: sel, decerr, len[7:0], beat[7:0], last_err.
- IDLE: all handshake outputs 0. If M_AWVALID: latch len=M_AWLEN, sel/decerr from decode, beat=0, last_err=0, go ADDR. Master holds AWVALID/AWADDR (no ready yet, AXI-legal).
- ADDR, hit: S_AWVALID[sel]=1; M_AWREADY=S_AWREADY[sel] (combinational). Handshake -> DATA.
- ADDR, decerr: M_AWREADY=1 for exactly one cycle, no S_AWVALID; -> DATA.
- DATA, hit: S_WVALID[sel]=M_WVALID; M_WREADY=S_WREADY[sel]. DATA, decerr: M_WREADY=1, beats sunk.
- Each accepted beat: beat increments. Termination is count-based: the beat with beat==len -> RESP. If M_WLAST != (beat==len) on any accepted beat, set last_err.
- RESP, hit: M_BVALID=S_BVALID[sel]; S_BREADY[sel]=M_BREADY; M_BRESP = S_BRESPsel, overridden to 2'b10 (SLVERR) if last_err and slave returned OKAY.
- RESP, decerr: M_BVALID=1, M_BRESP=2'b11.
- M_BVALID && M_BREADY -> IDLE.
- route_en = 1 in ADDR/DATA/RESP when !decerr, else 0; route_sel = sel whenever route_en, else 0.
- Only one transaction outstanding; new AW ignored (M_AWREADY=0) outside ADDR.
- Non-selected slave outputs are always 0.

## Timing
- Reset (async assert, sync-to-ACLK release by top level): state IDLE, sel=0, decerr=0, len=0, beat=0, last_err=0; all outputs 0, including M_BRESP=2'b00.
- Reset mid-transaction: immediate return to IDLE; no response issued; in-flight slave handshakes abandoned.
- AW latency: M_AWVALID sampled in IDLE at edge N; S_AWVALID up from cycle N+1; M_AWREADY in the same cycle as S_AWREADY (zero added latency in ADDR).
- W and B paths: pure combinational pass-through in their states, zero-cycle added latency; one dead cycle between B handshake and next AW acceptance (IDLE re-entry).
- AWLEN=0: single beat; the first accepted beat moves DATA -> RESP.
- AWLEN=255: beat counter reaches 255 without wrap; the transition fires on beat==255.
- Decode priority: an address matching both regions routes to slave 0.

## Test plan
- Single beat to slave 0: AWADDR=0x0000_0010, AWLEN=0, slaves always ready, BRESP0=OKAY -> S_AWVALID=01, route_sel=0, route_en=1, one W beat on S_WVALID[0], M_BRESP=00, back to IDLE.
- 4-beat burst to slave 1 with S_WREADY[1] toggling every cycle: AWADDR=0x4000_0100, AWLEN=3 -> exactly 4 beats forwarded, S_WVALID[0] never high, route_sel=1 throughout, M_BVALID mirrors S_BVALID[1].
- Decode error: AWADDR=0x9000_0000, AWLEN=2 -> no S_* valid, route_en=0, M_AWREADY one cycle, 3 beats sunk, M_BRESP=11.
- WLAST mismatch: AWLEN=1, M_WLAST on beat 0 -> still 2 beats taken, M_BRESP=10 when slave returns 00.
- Backpressure on B: M_BREADY held low 5 cycles -> M_BVALID/M_BRESP stable, S_BREADY low until M_BREADY rises; M_AWREADY stays 0 for a queued second AW.
- ARESET pulsed during DATA beat 2 of an AWLEN=7 burst -> all outputs 0 immediately, state IDLE; next transaction completes normally.
